// File: rtl/ppu_chr_fetch_seq.sv
// NTSC 2C02 CHR-bus fetch sequencer: dot/scanline timing, per-dot fetch addresses
// for background and sprite patterns, and latching of returned CHR bytes.
module ppu_chr_fetch_seq #(
    parameter int LAST_LINE = 261,
    parameter int VBL_FIRST = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        rendering_en,
    input  logic [14:0] vram_v,
    input  logic        bg_pt_sel,
    input  logic        spr_pt_sel,
    input  logic [7:0]  spr_tile,
    input  logic [2:0]  spr_row,
    input  logic [7:0]  chr_din,
    output logic [13:0] chr_ain,
    output logic        chr_read,
    output logic [13:0] chr_ain_o,
    output logic [8:0]  dot,
    output logic [8:0]  scanline,
    output logic        frame_odd,
    output logic [2:0]  spr_slot,
    output logic [7:0]  nt_byte,
    output logic [7:0]  at_byte,
    output logic [7:0]  pt_lo,
    output logic [7:0]  pt_hi,
    output logic        bg_tile_valid,
    output logic [7:0]  spr_lo,
    output logic [7:0]  spr_hi,
    output logic        spr_valid
);

    localparam logic [8:0] LAST_L = 9'(LAST_LINE);
    localparam logic [8:0] VBL_L  = 9'(VBL_FIRST);

    typedef enum logic [1:0] {
        REG_IDLE,
        REG_BG,
        REG_SPR,
        REG_NT_TAIL
    } region_e;

    logic [8:0]  dot_q, dot_d;
    logic [8:0]  scanline_q, scanline_d;
    logic        frame_odd_q, frame_odd_d;
    logic [13:0] chr_ain_q, chr_ain_d;
    logic        chr_read_q, chr_read_d;
    logic [13:0] chr_ain_o_q, chr_ain_o_d;
    logic [2:0]  spr_slot_q, spr_slot_d;
    logic [7:0]  nt_byte_q, nt_byte_d;
    logic [7:0]  at_byte_q, at_byte_d;
    logic [7:0]  pt_lo_q, pt_lo_d;
    logic [7:0]  pt_hi_q, pt_hi_d;
    logic        bg_tile_valid_q, bg_tile_valid_d;
    logic [7:0]  spr_lo_q, spr_lo_d;
    logic [7:0]  spr_hi_q, spr_hi_d;
    logic        spr_valid_q, spr_valid_d;

    logic        fetch_line;
    logic [5:0]  next_m1;
    logic [2:0]  cur_phase;
    region_e     next_region, cur_region;
    logic [13:0] nt_addr, at_addr, bg_pt_addr, spr_pt_addr;

    function automatic region_e region_of(input logic [8:0] d);
        region_e r;
        r = REG_IDLE;
        if (d >= 9'd1 && d <= 9'd256)
            r = REG_BG;
        else if (d >= 9'd257 && d <= 9'd320)
            r = REG_SPR;
        else if (d >= 9'd321 && d <= 9'd336)
            r = REG_BG;
        else if (d >= 9'd337)
            r = REG_NT_TAIL;
        return r;
    endfunction

    always_comb begin
        dot_d       = dot_q;
        scanline_d  = scanline_q;
        frame_odd_d = frame_odd_q;
        if (ce) begin
            // Odd frames with rendering on drop the last dot of the pre-render line.
            if (scanline_q == LAST_L && dot_q == 9'd339 && frame_odd_q && rendering_en) begin
                dot_d       = 9'd0;
                scanline_d  = 9'd0;
                frame_odd_d = ~frame_odd_q;
            end else if (dot_q == 9'd340) begin
                dot_d = 9'd0;
                if (scanline_q == LAST_L) begin
                    scanline_d  = 9'd0;
                    frame_odd_d = ~frame_odd_q;
                end else begin
                    scanline_d = scanline_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end
    end

    // Address decode looks at the dot being entered so chr_ain lines up with dot.
    always_comb begin
        next_m1     = dot_d[5:0] - 6'd1;
        next_region = region_of(dot_d);
        fetch_line  = rendering_en && (scanline_d < VBL_L || scanline_d == LAST_L);
        nt_addr     = {2'b10, vram_v[11:0]};
        at_addr     = {2'b10, vram_v[11:10], 4'b1111, vram_v[9:7], vram_v[4:2]};
        bg_pt_addr  = {1'b0, bg_pt_sel, nt_byte_q, 1'b0, vram_v[14:12]};
        spr_pt_addr = {1'b0, spr_pt_sel, spr_tile, 1'b0, spr_row};

        chr_ain_d   = chr_ain_q;
        chr_read_d  = chr_read_q;
        spr_slot_d  = spr_slot_q;
        chr_ain_o_d = chr_ain_o_q;

        if (ce) begin
            chr_read_d  = 1'b0;
            chr_ain_o_d = chr_ain_q;
            spr_slot_d  = (next_region == REG_SPR) ? next_m1[5:3] : 3'd0;
            if (fetch_line && next_region != REG_IDLE) begin
                if (next_m1[0]) begin
                    chr_read_d = 1'b1;
                end else begin
                    unique case (next_region)
                        REG_SPR: begin
                            case (next_m1[2:1])
                                2'd2:    chr_ain_d = spr_pt_addr;
                                2'd3:    chr_ain_d = spr_pt_addr | 14'h0008;
                                default: chr_ain_d = nt_addr;
                            endcase
                        end
                        REG_BG: begin
                            case (next_m1[2:1])
                                2'd0:    chr_ain_d = nt_addr;
                                2'd1:    chr_ain_d = at_addr;
                                2'd2:    chr_ain_d = bg_pt_addr;
                                default: chr_ain_d = bg_pt_addr | 14'h0008;
                            endcase
                        end
                        default: chr_ain_d = nt_addr;
                    endcase
                end
            end
        end
    end

    // Read data is captured against the dot whose read strobe is currently active.
    always_comb begin
        cur_phase  = dot_q[2:0] - 3'd1;
        cur_region = region_of(dot_q);

        nt_byte_d       = nt_byte_q;
        at_byte_d       = at_byte_q;
        pt_lo_d         = pt_lo_q;
        pt_hi_d         = pt_hi_q;
        spr_lo_d        = spr_lo_q;
        spr_hi_d        = spr_hi_q;
        bg_tile_valid_d = bg_tile_valid_q;
        spr_valid_d     = spr_valid_q;

        if (ce) begin
            bg_tile_valid_d = 1'b0;
            spr_valid_d     = 1'b0;
            if (chr_read_q) begin
                case (cur_region)
                    REG_BG: begin
                        case (cur_phase)
                            3'd1: nt_byte_d = chr_din;
                            3'd3: at_byte_d = chr_din;
                            3'd5: pt_lo_d   = chr_din;
                            3'd7: begin
                                pt_hi_d         = chr_din;
                                bg_tile_valid_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    REG_SPR: begin
                        if (cur_phase == 3'd5) begin
                            spr_lo_d = chr_din;
                        end else if (cur_phase == 3'd7) begin
                            spr_hi_d    = chr_din;
                            spr_valid_d = 1'b1;
                        end
                    end
                    REG_NT_TAIL: nt_byte_d = chr_din;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot_q           <= '0;
            scanline_q      <= '0;
            frame_odd_q     <= 1'b0;
            chr_ain_q       <= '0;
            chr_read_q      <= 1'b0;
            chr_ain_o_q     <= '0;
            spr_slot_q      <= '0;
            nt_byte_q       <= '0;
            at_byte_q       <= '0;
            pt_lo_q         <= '0;
            pt_hi_q         <= '0;
            bg_tile_valid_q <= 1'b0;
            spr_lo_q        <= '0;
            spr_hi_q        <= '0;
            spr_valid_q     <= 1'b0;
        end else begin
            dot_q           <= dot_d;
            scanline_q      <= scanline_d;
            frame_odd_q     <= frame_odd_d;
            chr_ain_q       <= chr_ain_d;
            chr_read_q      <= chr_read_d;
            chr_ain_o_q     <= chr_ain_o_d;
            spr_slot_q      <= spr_slot_d;
            nt_byte_q       <= nt_byte_d;
            at_byte_q       <= at_byte_d;
            pt_lo_q         <= pt_lo_d;
            pt_hi_q         <= pt_hi_d;
            bg_tile_valid_q <= bg_tile_valid_d;
            spr_lo_q        <= spr_lo_d;
            spr_hi_q        <= spr_hi_d;
            spr_valid_q     <= spr_valid_d;
        end
    end

    assign dot           = dot_q;
    assign scanline      = scanline_q;
    assign frame_odd     = frame_odd_q;
    assign chr_ain       = chr_ain_q;
    assign chr_read      = chr_read_q;
    assign chr_ain_o     = chr_ain_o_q;
    assign spr_slot      = spr_slot_q;
    assign nt_byte       = nt_byte_q;
    assign at_byte       = at_byte_q;
    assign pt_lo         = pt_lo_q;
    assign pt_hi         = pt_hi_q;
    assign bg_tile_valid = bg_tile_valid_q;
    assign spr_lo        = spr_lo_q;
    assign spr_hi        = spr_hi_q;
    assign spr_valid     = spr_valid_q;

endmodule

// File: tb/tb_ppu_chr_fetch_seq.sv
// Directed bench for ppu_chr_fetch_seq; a shortened frame keeps multi-frame
// odd/even skip checks within a small cycle count.
module tb_ppu_chr_fetch_seq;

    localparam int LAST_LINE = 20;
    localparam int VBL_FIRST = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        rendering_en;
    logic [14:0] vram_v;
    logic        bg_pt_sel;
    logic        spr_pt_sel;
    logic [7:0]  spr_tile;
    logic [2:0]  spr_row;
    logic [7:0]  chr_din;
    logic [13:0] chr_ain;
    logic        chr_read;
    logic [13:0] chr_ain_o;
    logic [8:0]  dot;
    logic [8:0]  scanline;
    logic        frame_odd;
    logic [2:0]  spr_slot;
    logic [7:0]  nt_byte, at_byte, pt_lo, pt_hi;
    logic        bg_tile_valid;
    logic [7:0]  spr_lo, spr_hi;
    logic        spr_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ppu_chr_fetch_seq #(.LAST_LINE(LAST_LINE), .VBL_FIRST(VBL_FIRST)) dut (
        .clk(clk), .reset(reset), .ce(ce), .rendering_en(rendering_en),
        .vram_v(vram_v), .bg_pt_sel(bg_pt_sel), .spr_pt_sel(spr_pt_sel),
        .spr_tile(spr_tile), .spr_row(spr_row), .chr_din(chr_din),
        .chr_ain(chr_ain), .chr_read(chr_read), .chr_ain_o(chr_ain_o),
        .dot(dot), .scanline(scanline), .frame_odd(frame_odd), .spr_slot(spr_slot),
        .nt_byte(nt_byte), .at_byte(at_byte), .pt_lo(pt_lo), .pt_hi(pt_hi),
        .bg_tile_valid(bg_tile_valid), .spr_lo(spr_lo), .spr_hi(spr_hi),
        .spr_valid(spr_valid)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic advanceTo(input int line, input int d);
        int budget;
        budget = 20000;
        while (!(scanline == 9'(line) && dot == 9'(d)) && budget > 0) begin
            applyStimulus(1);
            budget--;
        end
        checks++;
        assert (scanline == 9'(line) && dot == 9'(d)) else begin
            errors++;
            $error("[TB] FAIL advance line %0d dot %0d observed line %0d dot %0d",
                   line, d, scanline, dot);
        end
    endtask

    initial begin
        int read_seen;
        int ain_changed;
        int steps;

        reset        = 1'b1;
        ce           = 1'b1;
        rendering_en = 1'b1;
        vram_v       = 15'h3043;
        bg_pt_sel    = 1'b1;
        spr_pt_sel   = 1'b0;
        spr_tile     = 8'hFD;
        spr_row      = 3'd0;
        chr_din      = 8'h77;
        #7;
        checkOutput("rst_dot", 16'(dot), 16'h0);
        checkOutput("rst_ain", 16'(chr_ain), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // Mid-frame asynchronous reset
        advanceTo(5, 100);
        checkOutput("pre_rst_nt", 16'(nt_byte), 16'h77);
        checkOutput("pre_rst_read", 16'(chr_read), 16'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_dot", 16'(dot), 16'h0);
        checkOutput("arst_line", 16'(scanline), 16'h0);
        checkOutput("arst_ain", 16'(chr_ain), 16'h0);
        checkOutput("arst_read", 16'(chr_read), 16'h0);
        checkOutput("arst_nt", 16'(nt_byte), 16'h0);
        @(negedge clk);
        chr_din = 8'h5A;
        reset   = 1'b0;
        applyStimulus(1);
        checkOutput("rel_dot", 16'(dot), 16'd1);
        checkOutput("rel_line", 16'(scanline), 16'd0);

        // Background tile fetch on line 0
        checkOutput("bg_nt_ain_d1", 16'(chr_ain), 16'h2043);
        checkOutput("bg_nt_read_d1", 16'(chr_read), 16'h0);
        applyStimulus(1);
        checkOutput("bg_nt_ain_d2", 16'(chr_ain), 16'h2043);
        checkOutput("bg_nt_read_d2", 16'(chr_read), 16'h1);
        checkOutput("bg_ain_o_d2", 16'(chr_ain_o), 16'h2043);
        applyStimulus(1);
        checkOutput("bg_nt_byte", 16'(nt_byte), 16'h5A);
        checkOutput("bg_at_ain", 16'(chr_ain), 16'h23C0);
        applyStimulus(2);
        checkOutput("bg_at_byte", 16'(at_byte), 16'h5A);
        checkOutput("bg_ptlo_ain", 16'(chr_ain), 16'h15A3);
        checkOutput("bg_ptlo_read", 16'(chr_read), 16'h0);
        applyStimulus(1);
        checkOutput("bg_ptlo_read_d6", 16'(chr_read), 16'h1);
        applyStimulus(1);
        checkOutput("bg_pt_lo", 16'(pt_lo), 16'h5A);
        checkOutput("bg_pthi_ain", 16'(chr_ain), 16'h15AB);
        chr_din = 8'hC3;
        applyStimulus(1);
        checkOutput("bg_pthi_read", 16'(chr_read), 16'h1);
        checkOutput("bg_valid_d8", 16'(bg_tile_valid), 16'h0);
        applyStimulus(1);
        checkOutput("bg_dot9", 16'(dot), 16'd9);
        checkOutput("bg_valid_d9", 16'(bg_tile_valid), 16'h1);
        checkOutput("bg_pt_hi", 16'(pt_hi), 16'hC3);
        applyStimulus(1);
        checkOutput("bg_valid_d10", 16'(bg_tile_valid), 16'h0);

        // rendering_en drops while the read at dot 6 is active
        advanceTo(1, 6);
        checkOutput("drop_read_d6", 16'(chr_read), 16'h1);
        chr_din      = 8'hE7;
        rendering_en = 1'b0;
        applyStimulus(1);
        checkOutput("drop_pt_lo", 16'(pt_lo), 16'hE7);
        checkOutput("drop_read_d7", 16'(chr_read), 16'h0);
        checkOutput("drop_ain_hold", 16'(chr_ain), 16'h1C33);
        read_seen = 0;
        steps = 0;
        while (scanline == 9'd1 && steps < 400) begin
            if (chr_read) read_seen++;
            applyStimulus(1);
            steps++;
        end
        checkOutput("drop_no_read", 16'(read_seen), 16'h0);
        checkOutput("drop_line_end", 16'(scanline), 16'd2);
        rendering_en = 1'b1;

        // Sprite slot 0 fetch on line 10
        advanceTo(10, 261);
        chr_din = 8'h3C;
        checkOutput("spr_lo_ain", 16'(chr_ain), 16'h0FD0);
        checkOutput("spr_lo_noread", 16'(chr_read), 16'h0);
        checkOutput("spr_slot0", 16'(spr_slot), 16'h0);
        applyStimulus(1);
        checkOutput("spr_lo_read", 16'(chr_read), 16'h1);
        applyStimulus(1);
        chr_din = 8'hA5;
        checkOutput("spr_lo", 16'(spr_lo), 16'h3C);
        checkOutput("spr_hi_ain", 16'(chr_ain), 16'h0FD8);
        checkOutput("spr_ain_o_d263", 16'(chr_ain_o), 16'h0FD0);
        applyStimulus(1);
        checkOutput("spr_hi_read", 16'(chr_read), 16'h1);
        checkOutput("spr_valid_d264", 16'(spr_valid), 16'h0);
        applyStimulus(1);
        checkOutput("spr_hi", 16'(spr_hi), 16'hA5);
        checkOutput("spr_valid_d265", 16'(spr_valid), 16'h1);
        checkOutput("spr_ain_o_d265", 16'(chr_ain_o), 16'h0FD8);
        checkOutput("spr_slot1", 16'(spr_slot), 16'h1);
        applyStimulus(1);
        checkOutput("spr_valid_d266", 16'(spr_valid), 16'h0);

        // ce low freezes the sequencer
        ce = 1'b0;
        applyStimulus(3);
        checkOutput("ce_hold_dot", 16'(dot), 16'd266);
        ce = 1'b1;

        // Vertical blank lines never read and leave chr_ain alone
        advanceTo(VBL_FIRST - 1, 340);
        checkOutput("vbl_pre_ain", 16'(chr_ain), 16'h2043);
        applyStimulus(1);
        read_seen   = 0;
        ain_changed = 0;
        for (int i = 0; i < (LAST_LINE - VBL_FIRST) * 341; i++) begin
            if (chr_read) read_seen++;
            if (chr_ain !== 14'h2043) ain_changed++;
            applyStimulus(1);
        end
        checkOutput("vbl_no_read", 16'(read_seen), 16'h0);
        checkOutput("vbl_ain_same", 16'(ain_changed), 16'h0);
        checkOutput("vbl_end_line", 16'(scanline), 16'(LAST_LINE));

        // Even frame keeps dot 340, odd frame with rendering skips it
        advanceTo(LAST_LINE, 339);
        checkOutput("even_frame", 16'(frame_odd), 16'h0);
        applyStimulus(1);
        checkOutput("even_dot340", 16'(dot), 16'd340);
        applyStimulus(1);
        checkOutput("even_wrap_odd", 16'(frame_odd), 16'h1);
        advanceTo(LAST_LINE, 339);
        applyStimulus(1);
        checkOutput("odd_skip_dot", 16'(dot), 16'd0);
        checkOutput("odd_skip_line", 16'(scanline), 16'd0);
        checkOutput("odd_skip_frame", 16'(frame_odd), 16'h0);

        advanceTo(LAST_LINE, 339);
        applyStimulus(2);
        checkOutput("odd2_frame", 16'(frame_odd), 16'h1);
        advanceTo(LAST_LINE, 339);
        rendering_en = 1'b0;
        applyStimulus(1);
        checkOutput("norend_dot340", 16'(dot), 16'd340);
        checkOutput("norend_line", 16'(scanline), 16'(LAST_LINE));
        checkOutput("norend_read", 16'(chr_read), 16'h0);
        applyStimulus(1);
        checkOutput("norend_wrap_dot", 16'(dot), 16'd0);
        checkOutput("norend_wrap_frame", 16'(frame_odd), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
